// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the staged reset sequencer.
// Holds the FSM state encoding, the counter-width helper and default parameters.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT    = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STAGGER   = 2'd2,
        ST_RUN       = 2'd3
    } seq_state_e;

    localparam int DEF_NUM_OUT      = 4;
    localparam int DEF_MIN_ASSERT   = 4;
    localparam int DEF_LOCK_CYCLES  = 16;
    localparam int DEF_STAGE_CYCLES = 8;

    // Bits needed to hold values 0..max_val, never less than one bit.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs (PLL lock, keys, switches).
// Both stages clear to 0 on the asynchronous active-low reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two back-to-back capture stages.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset controller: holds all domain resets low, waits for a stable PLL
// lock, then releases one active-low reset at a time, re-sequencing on any abort.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_OUT      = DEF_NUM_OUT,
    parameter int MIN_ASSERT   = DEF_MIN_ASSERT,
    parameter int LOCK_CYCLES  = DEF_LOCK_CYCLES,
    parameter int STAGE_CYCLES = DEF_STAGE_CYCLES
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       lock,
    input  logic                       soft_reset,
    output logic [NUM_OUT-1:0]         rst_out_n,
    output logic                       seq_done,
    output logic [cnt_w(NUM_OUT)-1:0]  stage
);

    localparam int SW = cnt_w(NUM_OUT);
    localparam int AW = cnt_w(MIN_ASSERT - 1);
    localparam int LW = cnt_w(LOCK_CYCLES - 1);
    localparam int TW = cnt_w(STAGE_CYCLES - 1);

    logic              lock_s;
    logic              abort_s;
    seq_state_e        state_r;
    logic [AW-1:0]     assert_cnt_r;
    logic [LW-1:0]     lock_cnt_r;
    logic [TW-1:0]     stage_cnt_r;
    logic [NUM_OUT-1:0] rst_out_n_r;
    logic              seq_done_r;
    logic [SW-1:0]     stage_r;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (lock),
        .q       (lock_s)
    );

    // Conditions that tear down a sequence in progress.
    always_comb begin
        abort_s = 1'b0;
        if (soft_reset || !lock_s) begin
            abort_s = 1'b1;
        end else begin
            abort_s = 1'b0;
        end
    end

    // Sequencer FSM; every output is a flop so the reset tree sees no glitches.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_ASSERT;
            assert_cnt_r <= AW'(0);
            lock_cnt_r   <= LW'(0);
            stage_cnt_r  <= TW'(0);
            rst_out_n_r  <= {NUM_OUT{1'b0}};
            seq_done_r   <= 1'b0;
            stage_r      <= SW'(0);
        end else begin
            case (state_r)
                ST_ASSERT: begin
                    if (soft_reset) begin
                        assert_cnt_r <= AW'(0);
                    end else if (assert_cnt_r == AW'(MIN_ASSERT - 1)) begin
                        assert_cnt_r <= AW'(0);
                        state_r      <= ST_WAIT_LOCK;
                    end else begin
                        assert_cnt_r <= assert_cnt_r + AW'(1);
                    end
                end
                // Outputs are already low here, so a lock dropout only restarts the stability count.
                ST_WAIT_LOCK: begin
                    if (soft_reset) begin
                        lock_cnt_r <= LW'(0);
                        state_r    <= ST_ASSERT;
                    end else if (!lock_s) begin
                        lock_cnt_r <= LW'(0);
                    end else if (lock_cnt_r == LW'(LOCK_CYCLES - 1)) begin
                        lock_cnt_r  <= LW'(0);
                        rst_out_n_r <= NUM_OUT'(1);
                        stage_r     <= SW'(1);
                        if (NUM_OUT == 1) begin
                            seq_done_r <= 1'b1;
                            state_r    <= ST_RUN;
                        end else begin
                            state_r    <= ST_STAGGER;
                        end
                    end else begin
                        lock_cnt_r <= lock_cnt_r + LW'(1);
                    end
                end
                ST_STAGGER: begin
                    if (abort_s) begin
                        stage_cnt_r <= TW'(0);
                        rst_out_n_r <= {NUM_OUT{1'b0}};
                        seq_done_r  <= 1'b0;
                        stage_r     <= SW'(0);
                        state_r     <= ST_ASSERT;
                    end else if (stage_cnt_r == TW'(STAGE_CYCLES - 1)) begin
                        stage_cnt_r <= TW'(0);
                        rst_out_n_r <= NUM_OUT'({rst_out_n_r, 1'b1});
                        stage_r     <= stage_r + SW'(1);
                        if (stage_r == SW'(NUM_OUT - 1)) begin
                            seq_done_r <= 1'b1;
                            state_r    <= ST_RUN;
                        end else begin
                            state_r    <= ST_STAGGER;
                        end
                    end else begin
                        stage_cnt_r <= stage_cnt_r + TW'(1);
                    end
                end
                ST_RUN: begin
                    if (abort_s) begin
                        rst_out_n_r <= {NUM_OUT{1'b0}};
                        seq_done_r  <= 1'b0;
                        stage_r     <= SW'(0);
                        state_r     <= ST_ASSERT;
                    end else begin
                        state_r     <= ST_RUN;
                    end
                end
                default: begin
                    state_r      <= ST_ASSERT;
                    assert_cnt_r <= AW'(0);
                    lock_cnt_r   <= LW'(0);
                    stage_cnt_r  <= TW'(0);
                    rst_out_n_r  <= {NUM_OUT{1'b0}};
                    seq_done_r   <= 1'b0;
                    stage_r      <= SW'(0);
                end
            endcase
        end
    end

    assign rst_out_n = rst_out_n_r;
    assign seq_done  = seq_done_r;
    assign stage     = stage_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with default parameters: release schedule,
// soft/lock aborts, a release suppressed by abort, and asynchronous reset.
module tb_reset_sequencer;

    logic       clock;
    logic       reset_n;
    logic       lock;
    logic       soft_reset;
    logic [3:0] rst_out_n;
    logic       seq_done;
    logic [2:0] stage;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    reset_sequencer dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .lock       (lock),
        .soft_reset (soft_reset),
        .rst_out_n  (rst_out_n),
        .seq_done   (seq_done),
        .stage      (stage)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    typedef struct {
        int         edge_no;
        logic [3:0] rst;
        logic       done;
        logic [2:0] stg;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [3:0] er, input logic ed, input logic [2:0] es);
        total++;
        if (rst_out_n !== er || seq_done !== ed || stage !== es) begin
            bad++;
            $display("FAIL %s edge=%0d: got rst=%b done=%b stage=%0d, want rst=%b done=%b stage=%0d",
                     name, edge_n, rst_out_n, seq_done, stage, er, ed, es);
        end
    endtask

    // Advance to the negedge following edge e (edges counted since reset release).
    task automatic run_to(input int e);
        while (edge_n < e) begin
            @(posedge clock);
            edge_n++;
        end
        @(negedge clock);
    endtask

    task automatic do_reset(input logic lk);
        reset_n    = 1'b0;
        soft_reset = 1'b0;
        lock       = lk;
        repeat (3) @(negedge clock);
        check("reset_state", 4'b0000, 1'b0, 3'd0);
        reset_n = 1'b1;
        edge_n  = 0;
    endtask

    // Released resets must always form a contiguous run starting at bit 0.
    always @(negedge clock) begin
        total++;
        if (((rst_out_n + 4'd1) & rst_out_n) !== 4'd0) begin
            bad++;
            $display("FAIL monotonic: got rst=%b, want contiguous low-order ones", rst_out_n);
        end
    end

    initial begin
        reset_n    = 1'b0;
        lock       = 1'b1;
        soft_reset = 1'b0;

        vecs[0] = '{19, 4'b0000, 1'b0, 3'd0};
        vecs[1] = '{20, 4'b0001, 1'b0, 3'd1};
        vecs[2] = '{27, 4'b0001, 1'b0, 3'd1};
        vecs[3] = '{28, 4'b0011, 1'b0, 3'd2};
        vecs[4] = '{35, 4'b0011, 1'b0, 3'd2};
        vecs[5] = '{36, 4'b0111, 1'b0, 3'd3};
        vecs[6] = '{43, 4'b0111, 1'b0, 3'd3};
        vecs[7] = '{44, 4'b1111, 1'b1, 3'd4};
        vecs[8] = '{47, 4'b1111, 1'b1, 3'd4};
        vecs[9] = '{49, 4'b1111, 1'b1, 3'd4};

        // Default schedule with lock steady high.
        do_reset(1'b1);
        for (int i = 0; i < 10; i++) begin
            run_to(vecs[i].edge_no);
            check("default_seq", vecs[i].rst, vecs[i].done, vecs[i].stg);
        end

        // Soft reset pulse in RUN, sampled at edge 50.
        soft_reset = 1'b1;
        run_to(50);
        soft_reset = 1'b0;
        check("soft_run_abort", 4'b0000, 1'b0, 3'd0);
        run_to(69);
        check("soft_run_wait", 4'b0000, 1'b0, 3'd0);
        run_to(70);
        check("soft_run_rel0", 4'b0001, 1'b0, 3'd1);

        // Lock low until edge 30.
        do_reset(1'b0);
        run_to(30);
        check("late_lock_hold", 4'b0000, 1'b0, 3'd0);
        lock = 1'b1;
        run_to(47);
        check("late_lock_pre", 4'b0000, 1'b0, 3'd0);
        run_to(48);
        check("late_lock_rel0", 4'b0001, 1'b0, 3'd1);
        run_to(55);
        check("late_lock_gap", 4'b0001, 1'b0, 3'd1);
        run_to(56);
        check("late_lock_rel1", 4'b0011, 1'b0, 3'd2);
        run_to(72);
        check("late_lock_done", 4'b1111, 1'b1, 3'd4);

        // One-cycle lock dropout at stage 2.
        do_reset(1'b1);
        run_to(30);
        lock = 1'b0;
        run_to(31);
        lock = 1'b1;
        run_to(32);
        check("lock_drop_pre", 4'b0011, 1'b0, 3'd2);
        run_to(33);
        check("lock_drop_abort", 4'b0000, 1'b0, 3'd0);
        run_to(52);
        check("lock_drop_wait", 4'b0000, 1'b0, 3'd0);
        run_to(53);
        check("lock_drop_rel0", 4'b0001, 1'b0, 3'd1);
        run_to(61);
        check("lock_drop_rel1", 4'b0011, 1'b0, 3'd2);

        // Soft reset coincident with the bit-2 release at edge 36.
        do_reset(1'b1);
        run_to(35);
        check("soft_rel_pre", 4'b0011, 1'b0, 3'd2);
        soft_reset = 1'b1;
        run_to(36);
        soft_reset = 1'b0;
        check("soft_rel_suppress", 4'b0000, 1'b0, 3'd0);
        run_to(55);
        check("soft_rel_wait", 4'b0000, 1'b0, 3'd0);
        run_to(56);
        check("soft_rel_rel0", 4'b0001, 1'b0, 3'd1);

        // Asynchronous reset pulse between clock edges mid-STAGGER.
        do_reset(1'b1);
        run_to(30);
        check("async_pre", 4'b0011, 1'b0, 3'd2);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_clear", 4'b0000, 1'b0, 3'd0);
        #2;
        reset_n = 1'b1;
        edge_n  = 0;
        run_to(19);
        check("async_restart_pre", 4'b0000, 1'b0, 3'd0);
        run_to(20);
        check("async_restart_rel0", 4'b0001, 1'b0, 3'd1);
        run_to(44);
        check("async_restart_done", 4'b1111, 1'b1, 3'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
